regfile_sb: RTL and testbench

- Parametrised successor to the single-cycle core's 2R/1W register file.
- Two read ports, two prioritised write ports (A = ALU writeback, B = memory writeback), selectable reset image and optional write-to-read bypass.
- Per-register busy scoreboard: the decode stage reserves a destination at issue, and any write to that register releases it.
- Sits between decode/issue and the writeback stages of the multicycle/pipelined datapath.

---
 rtl/regfile_sb.sv | 136 +++++++++++++
 tb/tb_regfile_sb.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Multi-ported register file with prioritised dual writeback, optional bypass and a
// per-register busy scoreboard for issue-time destination reservation.
module regfile_sb #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int ZERO_REG   = 1,
    parameter int RESET_MODE = 1,
    parameter int BYPASS     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en_a,
    input  logic [ADDR_W-1:0] wr_addr_a,
    input  logic [DATA_W-1:0] wr_data_a,
    input  logic              wr_en_b,
    input  logic [ADDR_W-1:0] wr_addr_b,
    input  logic [DATA_W-1:0] wr_data_b,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ok,
    output logic [ADDR_W:0]   busy_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;

    logic wa_ok;
    logic wb_ok;
    logic hit_a1, hit_b1, hit_a2, hit_b2;
    logic [DATA_W-1:0] arr1;
    logic [DATA_W-1:0] arr2;

    function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + {{ADDR_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // Port B outranks port A when both forward to the same read address.
    function automatic logic [DATA_W-1:0] port_data(
        input logic              zero,
        input logic              hit_b,
        input logic              hit_a,
        input logic [DATA_W-1:0] arr_val
    );
        if (zero)       return '0;
        else if (hit_b) return wr_data_b;
        else if (hit_a) return wr_data_a;
        else            return arr_val;
    endfunction

    assign wa_ok = wr_en_a && !is_zero(wr_addr_a);
    assign wb_ok = wr_en_b && !is_zero(wr_addr_b);

    always_comb begin
        hit_a1 = (BYPASS != 0) && wa_ok && (wr_addr_a == rd_addr1);
        hit_b1 = (BYPASS != 0) && wb_ok && (wr_addr_b == rd_addr1);
        hit_a2 = (BYPASS != 0) && wa_ok && (wr_addr_a == rd_addr2);
        hit_b2 = (BYPASS != 0) && wb_ok && (wr_addr_b == rd_addr2);
        arr1   = mem[rd_addr1];
        arr2   = mem[rd_addr2];
    end

    always_comb begin
        rd_data1 = port_data(is_zero(rd_addr1), hit_b1, hit_a1, arr1);
        rd_data2 = port_data(is_zero(rd_addr2), hit_b2, hit_a2, arr2);
        rd_busy1 = busy[rd_addr1] && !is_zero(rd_addr1) && !hit_a1 && !hit_b1;
        rd_busy2 = busy[rd_addr2] && !is_zero(rd_addr2) && !hit_a2 && !hit_b2;
    end

    // Reservation looks only at the registered busy bit, so a register released
    // this very cycle still refuses a new producer until the next cycle.
    always_comb begin
        if (is_zero(rsv_addr)) begin
            rsv_ok = rsv_en;
        end else begin
            rsv_ok = rsv_en && !busy[rsv_addr];
        end
    end

    // Writes release first, then an accepted reservation re-arms the bit.
    always_comb begin
        busy_nxt = busy;
        if (wa_ok) begin
            busy_nxt[wr_addr_a] = 1'b0;
        end
        if (wb_ok) begin
            busy_nxt[wr_addr_b] = 1'b0;
        end
        if (rsv_ok && !is_zero(rsv_addr)) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_count <= popcount(busy_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (RESET_MODE != 0) ? DATA_W'(i) : '0;
            end
        end else begin
            if (wa_ok) begin
                mem[wr_addr_a] <= wr_data_a;
            end
            if (wb_ok) begin
                mem[wr_addr_b] <= wr_data_b;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: per-cycle vector table for combinational outputs, with
// the post-edge busy_count expectation queued and compared after the clock edge.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr1, rd_addr2;
    logic [31:0] rd_data1, rd_data2;
    logic        rd_busy1, rd_busy2;
    logic        wr_en_a, wr_en_b, rsv_en;
    logic [4:0]  wr_addr_a, wr_addr_b, rsv_addr;
    logic [31:0] wr_data_a, wr_data_b;
    logic        rsv_ok;
    logic [5:0]  busy_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .RESET_MODE(1), .BYPASS(1)) dut (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
        .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
        .busy_count(busy_count)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic [4:0]  ra1, ra2;
        logic        wea;
        logic [4:0]  waa;
        logic [31:0] wda;
        logic        web;
        logic [4:0]  wab;
        logic [31:0] wdb;
        logic        rsv;
        logic [4:0]  rsa;
        logic [31:0] d1, d2;
        logic        b1, b2, ok;
        logic [5:0]  cnt;
    } vec_t;

    typedef struct {
        string      name;
        logic [5:0] cnt;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic rst,
                                input logic [4:0] ra1, input logic [4:0] ra2,
                                input logic wea, input logic [4:0] waa, input logic [31:0] wda,
                                input logic web, input logic [4:0] wab, input logic [31:0] wdb,
                                input logic rsv, input logic [4:0] rsa,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic b1, input logic b2, input logic ok,
                                input logic [5:0] cnt);
        vec_t v;
        v.name = nm; v.rst = rst; v.ra1 = ra1; v.ra2 = ra2;
        v.wea = wea; v.waa = waa; v.wda = wda;
        v.web = web; v.wab = wab; v.wdb = wdb;
        v.rsv = rsv; v.rsa = rsa;
        v.d1 = d1; v.d2 = d2; v.b1 = b1; v.b2 = b2; v.ok = ok; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        sb_t e;
        //                 name          rst ra1 ra2 wea waa wda           web wab wdb           rsv rsa d1            d2            b1 b2 ok cnt
        vecs.push_back(mk("reset_img",   0,  7, 31, 0,  0, 32'h0,        0,  0, 32'h0,        1,  3, 32'h7,        32'h1F,       0, 0, 1, 1));
        vecs.push_back(mk("busy_r3",     0,  3,  0, 0,  0, 32'h0,        0,  0, 32'h0,        0,  0, 32'h3,        32'h0,        1, 0, 0, 1));
        vecs.push_back(mk("rel_r3",      0,  3,  0, 0,  0, 32'h0,        1,  3, 32'h33,       0,  0, 32'h33,       32'h0,        0, 0, 0, 0));
        vecs.push_back(mk("wr_ab_same",  0,  5,  3, 1,  5, 32'hDEADBEEF, 1,  5, 32'h12345678, 0,  0, 32'h12345678, 32'h33,       0, 0, 0, 0));
        vecs.push_back(mk("after_ab",    0,  5,  0, 0,  0, 32'h0,        0,  0, 32'h0,        0,  0, 32'h12345678, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk("zero_wr",     0,  0,  5, 1,  0, 32'hFFFFFFFF, 0,  0, 32'h0,        1,  0, 32'h0,        32'h12345678, 0, 0, 1, 0));
        vecs.push_back(mk("zero_rd",     0,  0,  4, 0,  0, 32'h0,        0,  0, 32'h0,        0,  0, 32'h0,        32'h4,        0, 0, 0, 0));
        vecs.push_back(mk("rsv_r9",      0,  9,  0, 0,  0, 32'h0,        0,  0, 32'h0,        1,  9, 32'h9,        32'h0,        0, 0, 1, 1));
        vecs.push_back(mk("r9_busy",     0,  9,  0, 0,  0, 32'h0,        0,  0, 32'h0,        1,  9, 32'h9,        32'h0,        1, 0, 0, 1));
        vecs.push_back(mk("wr_r9",       0,  9,  0, 0,  0, 32'h0,        1,  9, 32'hA5,       1,  9, 32'hA5,       32'h0,        0, 0, 0, 0));
        vecs.push_back(mk("r9_free",     0,  9,  0, 0,  0, 32'h0,        0,  0, 32'h0,        0,  0, 32'hA5,       32'h0,        0, 0, 0, 0));
        vecs.push_back(mk("rsv_r3",      0,  3,  0, 0,  0, 32'h0,        0,  0, 32'h0,        1,  3, 32'h33,       32'h0,        0, 0, 1, 1));
        vecs.push_back(mk("rsv_r4",      0,  3,  4, 0,  0, 32'h0,        0,  0, 32'h0,        1,  4, 32'h33,       32'h4,        1, 0, 1, 2));
        vecs.push_back(mk("wr_r3_r4",    0,  3,  4, 1,  3, 32'h300,      1,  4, 32'h400,      0,  0, 32'h300,      32'h400,      0, 0, 0, 0));
        vecs.push_back(mk("rsv_wr_r6",   0,  6,  3, 1,  6, 32'h66,       0,  0, 32'h0,        1,  6, 32'h66,       32'h300,      0, 0, 1, 1));
        vecs.push_back(mk("r6_busy",     0,  6,  4, 0,  0, 32'h0,        0,  0, 32'h0,        0,  0, 32'h66,       32'h400,      1, 0, 0, 1));
        vecs.push_back(mk("rsv_r10",     0, 10,  0, 0,  0, 32'h0,        0,  0, 32'h0,        1, 10, 32'hA,        32'h0,        0, 0, 1, 2));
        vecs.push_back(mk("rsv_r11",     0, 10,  6, 0,  0, 32'h0,        0,  0, 32'h0,        1, 11, 32'hA,        32'h66,       1, 1, 1, 3));
        vecs.push_back(mk("mid_reset",   1, 11, 10, 1, 13, 32'hBAD,      0,  0, 32'h0,        1, 12, 32'hB,        32'hA,        1, 1, 1, 0));
        vecs.push_back(mk("post_rst_a",  0, 10, 11, 0,  0, 32'h0,        0,  0, 32'h0,        0,  0, 32'hA,        32'hB,        0, 0, 0, 0));
        vecs.push_back(mk("post_rst_b",  0, 13,  6, 0,  0, 32'h0,        0,  0, 32'h0,        0,  0, 32'hD,        32'h6,        0, 0, 0, 0));
        vecs.push_back(mk("post_rst_c",  0, 12,  5, 0,  0, 32'h0,        0,  0, 32'h0,        1, 12, 32'hC,        32'h5,        0, 0, 1, 1));
        vecs.push_back(mk("byp_a_b",     0, 20, 21, 1, 20, 32'h2020,     1, 21, 32'h2121,     0,  0, 32'h2020,     32'h2121,     0, 0, 0, 1));
        vecs.push_back(mk("zero_b",      0,  0, 20, 0,  0, 32'h0,        1,  0, 32'hFFFFFFFF, 0,  0, 32'h0,        32'h2020,     0, 0, 0, 1));
        vecs.push_back(mk("wr_r12_b",    0, 12, 21, 1, 12, 32'h1212,     0,  0, 32'h0,        0,  0, 32'h1212,     32'h2121,     0, 0, 0, 0));

        reset = 1'b1;
        rd_addr1 = '0; rd_addr2 = '0;
        wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
        wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy_count", 32'(busy_count), 32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset     = vecs[i].rst;
            rd_addr1  = vecs[i].ra1;   rd_addr2  = vecs[i].ra2;
            wr_en_a   = vecs[i].wea;   wr_addr_a = vecs[i].waa; wr_data_a = vecs[i].wda;
            wr_en_b   = vecs[i].web;   wr_addr_b = vecs[i].wab; wr_data_b = vecs[i].wdb;
            rsv_en    = vecs[i].rsv;   rsv_addr  = vecs[i].rsa;
            e.name = vecs[i].name; e.cnt = vecs[i].cnt;
            sb.push_back(e);
            #1;
            check({vecs[i].name, ".rd_data1"}, rd_data1, vecs[i].d1);
            check({vecs[i].name, ".rd_data2"}, rd_data2, vecs[i].d2);
            check({vecs[i].name, ".rd_busy1"}, 32'(rd_busy1), 32'(vecs[i].b1));
            check({vecs[i].name, ".rd_busy2"}, 32'(rd_busy2), 32'(vecs[i].b2));
            check({vecs[i].name, ".rsv_ok"},   32'(rsv_ok),   32'(vecs[i].ok));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check({e.name, ".busy_count"}, 32'(busy_count), 32'(e.cnt));
        end

        // Hand sequence: A and B collide on r5 once more, check stored value after the edge.
        @(negedge clk);
        reset = 1'b0; rsv_en = 1'b0;
        wr_en_a = 1'b1; wr_addr_a = 5'd5; wr_data_a = 32'hDEADBEEF;
        wr_en_b = 1'b1; wr_addr_b = 5'd5; wr_data_b = 32'h12345678;
        rd_addr1 = 5'd5; rd_addr2 = 5'd0;
        @(negedge clk);
        wr_en_a = 1'b0; wr_en_b = 1'b0;
        #1;
        check("ab_collide_stored", rd_data1, 32'h12345678);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
